fetch_decode_q: RTL and testbench
=================================

FETCH_DECODE_Q -- requirements
Module: fetch_decode_q

Interface
REQ-001 SHALL have parameter RESET, default 32'h0000_0000, PC value held by dec_pc after reset.
REQ-002 SHALL have parameter DEPTH, default 4, instruction-queue entries; power of two, 2..16.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port inst_mem_is_valid  in  1  fetch word valid this cycle.
REQ-006 SHALL have port inst_mem_read_data  in  32  fetched instruction.
REQ-007 SHALL have port inst_fetch_pc  in  32  PC of the fetched instruction.
REQ-008 SHALL have port fetch_ready  out  1  queue accepts a word this cycle.
REQ-009 SHALL have port stall  in  1  downstream hold; decode registers keep their value.
REQ-010 SHALL have port flush  in  1  discard queued and decoded instructions (taken branch/jump).
REQ-011 SHALL have port dec_valid  out  1  decode registers hold a live instruction.
REQ-012 SHALL have port dec_pc  out  32  PC of the decoded instruction.
REQ-013 SHALL have port dec_immediate  out  32  sign/zero-extended immediate.
REQ-014 SHALL have port dec_ctrl  out  8  {imm_sel, alu, lui, jal, jalr, branch, mem_write, mem_to_reg}.
REQ-015 SHALL have port dec_src1, dec_src2, dec_dest  out  5 each  rs1, rs2, rd fields.
REQ-016 SHALL have port dec_alu_op  out  3, and dec_arithsubtype  out  1.
REQ-017 SHALL have port exception  out  1, and exc_pc  out  32  sticky fault flag and first faulting PC.
REQ-018 SHALL have port q_count  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-019 SHALL push {inst_fetch_pc, inst_mem_read_data} when inst_mem_is_valid && fetch_ready && !flush.
REQ-020 SHALL drive fetch_ready = (q_count < DEPTH) && !exception; a valid word while fetch_ready=0 is dropped.
REQ-021 SHALL pop the head when q_count>0 && !stall && !flush && !exception; the popped entry is decoded into the dec_* registers at the same edge (1-cycle latency head->outputs).
REQ-022 SHALL, when !stall and no pop occurs, load dec_valid=0 and dec_ctrl=0; other dec_* fields hold.
REQ-023 SHALL hold all dec_* registers while stall=1 (no pop); push continues while space exists.
REQ-024 SHALL support push and pop in the same cycle; q_count unchanged; read/write pointers wrap modulo DEPTH.
REQ-025 SHALL decode immediates per RV32I: I-type for JALR/LOAD/ARITHI; shamt zero-extended for ARITHI SLL/SR; S, B, U (LUI), and J forms; 0 for ARITHR.
REQ-026 SHALL set dec_ctrl.imm_sel for JALR/LOAD/ARITHI, alu for ARITHI/ARITHR; dec_arithsubtype = instr[30] && !(ARITHI && func3==ADD).
REQ-027 SHALL treat any opcode outside {LUI, JAL, JALR, BRANCH, LOAD, STORE, ARITHI, ARITHR}, or a popped PC with [1:0]!=0, as a fault: exception<=1, exc_pc<=that PC, dec_valid<=0 on that edge.
REQ-028 SHALL keep exception sticky until reset; once set, no further pops or pushes occur.
REQ-029 SHALL, on flush, empty the queue (q_count<=0), set dec_valid<=0 and dec_ctrl<=0; flush overrides simultaneous push, pop and stall.

Reset
REQ-030 SHALL on reset set q_count=0, pointers=0, dec_valid=0, dec_ctrl=0, dec_pc=RESET, all other dec_* =0, exception=0, exc_pc=0.
REQ-031 SHALL give reset priority over flush, stall and push; a word presented during reset is dropped.

Configuration
REQ-032 SHALL, with IFQ_BYPASS_EN defined, load a valid incoming word directly into the dec_* registers (queue not written) when q_count==0 && !stall && !flush && !exception: memory->dec latency 1 cycle.
REQ-033 SHALL, without IFQ_BYPASS_EN, always route through the queue: memory->dec latency 2 cycles.

Structure
REQ-034 SHALL place opcode/func3 constants, NOP (32'h0000_0013), field ranges and dec_ctrl bit positions in the shared opcode package/header.
REQ-035 SHALL implement the queue as sub-module ifq_fifo (DEPTH, 64-bit entries, push/pop/flush, count); decode and fault logic stay in fetch_decode_q.

Verification
REQ-036 SHALL cover: 0x00500093 at PC 0x0 (no bypass) -> 2 edges later dec_valid=1, dec_immediate=5, dec_dest=1, imm_sel=alu=1.
REQ-037 SHALL cover: stall=1 with DEPTH=4, 6 valid words -> q_count reaches 4, fetch_ready=0, words 5-6 dropped, dec_* unchanged.
REQ-038 SHALL cover: flush together with a push at q_count=3 -> next cycle q_count=0, dec_valid=0, pushed word absent.
REQ-039 SHALL cover: opcode 7'h7F at PC 0x10 -> exception=1, exc_pc=0x10; later words ignored until reset.
REQ-040 SHALL cover: IFQ_BYPASS_EN, empty queue, 0xFFF00113 -> 1 edge later dec_immediate=32'hFFFF_FFFF, q_count stays 0.

Source files
------------

// File: rtl/fetch_decode_q_pkg.sv
// Shared RV32I opcode/func3 constants, instruction field ranges and dec_ctrl bit positions
// for the fetch queue and decode stage.
package fetch_decode_q_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_ARITHI = 7'b0010011,
        OP_ARITHR = 7'b0110011
    } opcode_e;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;
    localparam int F3_MSB  = 14;
    localparam int F3_LSB  = 12;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;
    localparam int SUB_BIT = 30;

    // dec_ctrl = {imm_sel, alu, lui, jal, jalr, branch, mem_write, mem_to_reg}
    localparam int CTRL_IMM_SEL    = 7;
    localparam int CTRL_ALU        = 6;
    localparam int CTRL_LUI        = 5;
    localparam int CTRL_JAL        = 4;
    localparam int CTRL_JALR       = 3;
    localparam int CTRL_BRANCH     = 2;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/fetch_decode_q_ifq_fifo.sv
// Instruction fetch queue: DEPTH entries of {pc, instr}, power-of-two wrapping pointers,
// flush empties the queue in one cycle.
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;

    always_ff @(posedge clk) begin
        if (push && !reset && !flush) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head is read combinationally so a pop decodes on the same edge.
    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/fetch_decode_q.sv
// Fetch queue plus RV32I decode stage with sticky fault capture.
// Define IFQ_BYPASS_EN to let a word arriving at an empty queue decode directly (1-cycle latency).
module fetch_decode_q
    import fetch_decode_q_pkg::*;
#(
    parameter logic [31:0] RESET = 32'h0000_0000,
    parameter int          DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inst_mem_is_valid,
    input  logic [31:0]            inst_mem_read_data,
    input  logic [31:0]            inst_fetch_pc,
    output logic                   fetch_ready,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   dec_valid,
    output logic [31:0]            dec_pc,
    output logic [31:0]            dec_immediate,
    output logic [7:0]             dec_ctrl,
    output logic [4:0]             dec_src1,
    output logic [4:0]             dec_src2,
    output logic [4:0]             dec_dest,
    output logic [2:0]             dec_alu_op,
    output logic                   dec_arithsubtype,
    output logic                   exception,
    output logic [31:0]            exc_pc,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    logic        dec_valid_reg;
    logic [31:0] dec_pc_reg;
    logic [31:0] dec_imm_reg;
    logic [7:0]  dec_ctrl_reg;
    logic [4:0]  dec_src1_reg;
    logic [4:0]  dec_src2_reg;
    logic [4:0]  dec_dest_reg;
    logic [2:0]  dec_alu_op_reg;
    logic        dec_sub_reg;
    logic        exception_reg;
    logic [31:0] exc_pc_reg;

    logic [CW-1:0] count;
    ifq_entry_t    head;
    ifq_entry_t    incoming;
    ifq_entry_t    src;
    logic          word_in;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          take;

    assign incoming    = '{pc: inst_fetch_pc, instr: inst_mem_read_data};
    assign fetch_ready = (count < DEPTH_C) && !exception_reg;
    assign word_in     = inst_mem_is_valid && fetch_ready && !flush;

`ifdef IFQ_BYPASS_EN
    assign bypass = word_in && (count == '0) && !stall && !exception_reg;
`else
    assign bypass = 1'b0;
`endif

    assign push = word_in && !bypass;
    assign pop  = (count != '0) && !stall && !flush && !exception_reg;
    assign take = pop || bypass;
    assign src  = bypass ? incoming : head;

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (incoming),
        .rd_data (head),
        .count   (count)
    );

    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] imm_next;
    logic [7:0]  ctrl_next;
    logic        fault_next;
    logic        sub_next;

    assign opcode = src.instr[OPC_MSB:OPC_LSB];
    assign func3  = src.instr[F3_MSB:F3_LSB];

    always_comb begin
        imm_next   = '0;
        ctrl_next  = '0;
        fault_next = 1'b0;
        case (opcode)
            OP_LUI: begin
                ctrl_next[CTRL_LUI] = 1'b1;
                imm_next = {src.instr[31:12], 12'b0};
            end
            OP_JAL: begin
                ctrl_next[CTRL_JAL] = 1'b1;
                imm_next = {{11{src.instr[31]}}, src.instr[31], src.instr[19:12],
                            src.instr[20], src.instr[30:21], 1'b0};
            end
            OP_JALR: begin
                ctrl_next[CTRL_JALR]    = 1'b1;
                ctrl_next[CTRL_IMM_SEL] = 1'b1;
                imm_next = {{20{src.instr[31]}}, src.instr[31:20]};
            end
            OP_BRANCH: begin
                ctrl_next[CTRL_BRANCH] = 1'b1;
                imm_next = {{19{src.instr[31]}}, src.instr[31], src.instr[7],
                            src.instr[30:25], src.instr[11:8], 1'b0};
            end
            OP_LOAD: begin
                ctrl_next[CTRL_IMM_SEL]    = 1'b1;
                ctrl_next[CTRL_MEM_TO_REG] = 1'b1;
                imm_next = {{20{src.instr[31]}}, src.instr[31:20]};
            end
            OP_STORE: begin
                ctrl_next[CTRL_MEM_WRITE] = 1'b1;
                imm_next = {{20{src.instr[31]}}, src.instr[31:25], src.instr[11:7]};
            end
            OP_ARITHI: begin
                ctrl_next[CTRL_IMM_SEL] = 1'b1;
                ctrl_next[CTRL_ALU]     = 1'b1;
                // Shift immediates carry funct7 in the upper bits; only shamt is an operand.
                if (func3 == F3_SLL || func3 == F3_SR) begin
                    imm_next = {27'b0, src.instr[24:20]};
                end else begin
                    imm_next = {{20{src.instr[31]}}, src.instr[31:20]};
                end
            end
            OP_ARITHR: begin
                ctrl_next[CTRL_ALU] = 1'b1;
            end
            default: begin
                fault_next = 1'b1;
            end
        endcase
        if (src.pc[1:0] != 2'b00) begin
            fault_next = 1'b1;
        end
    end

    assign sub_next = src.instr[SUB_BIT] && !((opcode == OP_ARITHI) && (func3 == F3_ADD));

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_valid_reg  <= 1'b0;
            dec_ctrl_reg   <= '0;
            dec_pc_reg     <= RESET;
            dec_imm_reg    <= '0;
            dec_src1_reg   <= '0;
            dec_src2_reg   <= '0;
            dec_dest_reg   <= '0;
            dec_alu_op_reg <= '0;
            dec_sub_reg    <= 1'b0;
            exception_reg  <= 1'b0;
            exc_pc_reg     <= '0;
        end else if (flush) begin
            dec_valid_reg <= 1'b0;
            dec_ctrl_reg  <= '0;
        end else if (take) begin
            if (fault_next) begin
                exception_reg <= 1'b1;
                exc_pc_reg    <= src.pc;
                dec_valid_reg <= 1'b0;
                dec_ctrl_reg  <= '0;
            end else begin
                dec_valid_reg  <= 1'b1;
                dec_ctrl_reg   <= ctrl_next;
                dec_pc_reg     <= src.pc;
                dec_imm_reg    <= imm_next;
                dec_src1_reg   <= src.instr[RS1_MSB:RS1_LSB];
                dec_src2_reg   <= src.instr[RS2_MSB:RS2_LSB];
                dec_dest_reg   <= src.instr[RD_MSB:RD_LSB];
                dec_alu_op_reg <= func3;
                dec_sub_reg    <= sub_next;
            end
        end else if (!stall) begin
            dec_valid_reg <= 1'b0;
            dec_ctrl_reg  <= '0;
        end
    end

    assign dec_valid        = dec_valid_reg;
    assign dec_pc           = dec_pc_reg;
    assign dec_immediate    = dec_imm_reg;
    assign dec_ctrl         = dec_ctrl_reg;
    assign dec_src1         = dec_src1_reg;
    assign dec_src2         = dec_src2_reg;
    assign dec_dest         = dec_dest_reg;
    assign dec_alu_op       = dec_alu_op_reg;
    assign dec_arithsubtype = dec_sub_reg;
    assign exception        = exception_reg;
    assign exc_pc           = exc_pc_reg;
    assign q_count          = count;

endmodule

// File: tb/tb_fetch_decode_q.sv
// Directed bench for fetch_decode_q: decode vector table plus stall, flush, stream and fault sequences.
module tb_fetch_decode_q;
    import fetch_decode_q_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;
`ifdef IFQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   inst_mem_is_valid;
    logic [31:0]            inst_mem_read_data;
    logic [31:0]            inst_fetch_pc;
    logic                   fetch_ready;
    logic                   stall;
    logic                   flush;
    logic                   dec_valid;
    logic [31:0]            dec_pc;
    logic [31:0]            dec_immediate;
    logic [7:0]             dec_ctrl;
    logic [4:0]             dec_src1;
    logic [4:0]             dec_src2;
    logic [4:0]             dec_dest;
    logic [2:0]             dec_alu_op;
    logic                   dec_arithsubtype;
    logic                   exception;
    logic [31:0]            exc_pc;
    logic [$clog2(DEPTH):0] q_count;

    fetch_decode_q #(
        .RESET (RESET_PC),
        .DEPTH (DEPTH)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .inst_mem_is_valid  (inst_mem_is_valid),
        .inst_mem_read_data (inst_mem_read_data),
        .inst_fetch_pc      (inst_fetch_pc),
        .fetch_ready        (fetch_ready),
        .stall              (stall),
        .flush              (flush),
        .dec_valid          (dec_valid),
        .dec_pc             (dec_pc),
        .dec_immediate      (dec_immediate),
        .dec_ctrl           (dec_ctrl),
        .dec_src1           (dec_src1),
        .dec_src2           (dec_src2),
        .dec_dest           (dec_dest),
        .dec_alu_op         (dec_alu_op),
        .dec_arithsubtype   (dec_arithsubtype),
        .exception          (exception),
        .exc_pc             (exc_pc),
        .q_count            (q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [7:0]  ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  alu;
        logic        sub;
    } vec_t;

    vec_t vecs [11];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        inst_mem_is_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        inst_mem_is_valid  = 1'b1;
        inst_mem_read_data = instr;
        inst_fetch_pc      = pc;
    endtask

    function automatic logic [31:0] addi_k(input int k);
        return (32'(k) << 20) | (32'(k) << 7) | 32'h0000_0013;
    endfunction

    initial begin
        //                instr          pc            imm           ctrl   rd  rs1 rs2 alu sub
        vecs[0]  = '{32'h0050_0093, 32'h0000_0000, 32'h0000_0005, 8'hC0, 1,  0,  5,  0, 0};
        vecs[1]  = '{32'hFFF0_0113, 32'h0000_0004, 32'hFFFF_FFFF, 8'hC0, 2,  0,  31, 0, 0};
        vecs[2]  = '{32'h4040_D193, 32'h0000_0008, 32'h0000_0004, 8'hC0, 3,  1,  4,  5, 1};
        vecs[3]  = '{32'h4073_02B3, 32'h0000_000C, 32'h0000_0000, 8'h40, 5,  6,  7,  0, 1};
        vecs[4]  = '{32'h1234_5537, 32'h0000_0010, 32'h1234_5000, 8'h20, 10, 8,  3,  5, 0};
        vecs[5]  = '{32'hFE21_AE23, 32'h0000_0014, 32'hFFFF_FFFC, 8'h02, 28, 3,  2,  2, 1};
        vecs[6]  = '{32'hFE20_8CE3, 32'h0000_0018, 32'hFFFF_FFF8, 8'h04, 25, 1,  2,  0, 1};
        vecs[7]  = '{32'h0100_00EF, 32'h0000_001C, 32'h0000_0010, 8'h10, 1,  0,  16, 0, 0};
        vecs[8]  = '{32'h0000_8067, 32'h0000_0020, 32'h0000_0000, 8'h88, 0,  1,  0,  0, 0};
        vecs[9]  = '{32'h0081_2203, 32'h0000_0024, 32'h0000_0008, 8'h81, 4,  2,  8,  2, 0};
        vecs[10] = '{NOP,           32'h0000_0028, 32'h0000_0000, 8'hC0, 0,  0,  0,  0, 0};

        inst_mem_read_data = 32'h0;
        inst_fetch_pc      = 32'h0;

        // Reset with a word presented: the word must be dropped.
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(addi_k(7), 32'h0000_0040);
        step(2);
        reset = 1'b0;
        inst_mem_is_valid = 1'b0;
        check("rst.q_count", 32'(q_count), 32'd0);
        check("rst.dec_valid", 32'(dec_valid), 32'd0);
        check("rst.dec_pc", dec_pc, RESET_PC);
        check("rst.dec_ctrl", 32'(dec_ctrl), 32'd0);
        check("rst.dec_imm", dec_immediate, 32'd0);
        check("rst.exception", 32'(exception), 32'd0);
        check("rst.exc_pc", exc_pc, 32'd0);
        check("rst.fetch_ready", 32'(fetch_ready), 32'd1);
        step(2);
        check("rst.word_dropped", 32'(q_count) | 32'(dec_valid), 32'd0);
        $display("txn reset: q_count=%0d dec_pc=0x%08h", q_count, dec_pc);

        // Decode table: one word at a time from an empty queue.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].instr, vecs[i].pc);
            step(1);
            inst_mem_is_valid = 1'b0;
            step(LAT - 1);
            check($sformatf("vec%0d.valid", i), 32'(dec_valid), 32'd1);
            check($sformatf("vec%0d.pc", i), dec_pc, vecs[i].pc);
            check($sformatf("vec%0d.imm", i), dec_immediate, vecs[i].imm);
            check($sformatf("vec%0d.ctrl", i), 32'(dec_ctrl), 32'(vecs[i].ctrl));
            check($sformatf("vec%0d.rd", i), 32'(dec_dest), 32'(vecs[i].rd));
            check($sformatf("vec%0d.rs1", i), 32'(dec_src1), 32'(vecs[i].rs1));
            check($sformatf("vec%0d.rs2", i), 32'(dec_src2), 32'(vecs[i].rs2));
            check($sformatf("vec%0d.alu", i), 32'(dec_alu_op), 32'(vecs[i].alu));
            check($sformatf("vec%0d.sub", i), 32'(dec_arithsubtype), 32'(vecs[i].sub));
            check($sformatf("vec%0d.q_count", i), 32'(q_count), 32'd0);
            $display("txn vec%0d: instr=0x%08h imm=0x%08h ctrl=0x%02h", i, vecs[i].instr,
                     dec_immediate, dec_ctrl);
        end
        step(1);
        check("idle.dec_valid", 32'(dec_valid), 32'd0);
        check("idle.dec_ctrl", 32'(dec_ctrl), 32'd0);
        check("idle.dec_imm_hold", dec_immediate, 32'h0000_0000);
        check("idle.dec_pc_hold", dec_pc, 32'h0000_0028);

        // Stall with six words: queue fills, last two dropped, decode held.
        do_reset();
        drive(32'h0050_0093, 32'h0000_0000);
        step(1);
        inst_mem_is_valid = 1'b0;
        step(LAT - 1);
        check("stall.pre_valid", 32'(dec_valid), 32'd1);
        stall = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            drive(addi_k(k), 32'(4 * k));
            step(1);
            check($sformatf("stall.q%0d", k), 32'(q_count), (k < 4) ? 32'(k) : 32'd4);
            check($sformatf("stall.ready%0d", k), 32'(fetch_ready), 32'(k < 4));
            check($sformatf("stall.hold_imm%0d", k), dec_immediate, 32'd5);
            check($sformatf("stall.hold_valid%0d", k), 32'(dec_valid), 32'd1);
            $display("txn stall push %0d: q_count=%0d fetch_ready=%0d", k, q_count, fetch_ready);
        end
        inst_mem_is_valid = 1'b0;
        stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check($sformatf("drain.imm%0d", k), dec_immediate, 32'(k));
            check($sformatf("drain.rd%0d", k), 32'(dec_dest), 32'(k));
            check($sformatf("drain.q%0d", k), 32'(q_count), 32'(4 - k));
            $display("txn drain %0d: imm=0x%08h q_count=%0d", k, dec_immediate, q_count);
        end
        step(1);
        check("drain.empty_valid", 32'(dec_valid), 32'd0);
        check("drain.empty_q", 32'(q_count), 32'd0);

        // Flush with a simultaneous push at q_count=3.
        do_reset();
        drive(32'h0050_0093, 32'h0000_0000);
        step(1);
        inst_mem_is_valid = 1'b0;
        step(LAT - 1);
        stall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            drive(addi_k(k), 32'(4 * k));
            step(1);
        end
        check("flush.pre_q", 32'(q_count), 32'd3);
        check("flush.pre_valid", 32'(dec_valid), 32'd1);
        flush = 1'b1;
        drive(addi_k(9), 32'h0000_0100);
        step(1);
        flush = 1'b0;
        inst_mem_is_valid = 1'b0;
        stall = 1'b0;
        check("flush.q", 32'(q_count), 32'd0);
        check("flush.valid", 32'(dec_valid), 32'd0);
        check("flush.ctrl", 32'(dec_ctrl), 32'd0);
        step(3);
        check("flush.absent_q", 32'(q_count), 32'd0);
        check("flush.absent_valid", 32'(dec_valid), 32'd0);
        $display("txn flush: q_count=%0d dec_valid=%0d", q_count, dec_valid);

        // Continuous stream: push and pop each cycle, pointers wrap twice.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(addi_k(k), 32'(4 * k));
            step(1);
            check($sformatf("stream.q%0d", k), 32'(q_count), 32'(LAT - 1));
            if (k - (LAT - 1) >= 1) begin
                check($sformatf("stream.imm%0d", k), dec_immediate, 32'(k - (LAT - 1)));
                check($sformatf("stream.valid%0d", k), 32'(dec_valid), 32'd1);
            end
            $display("txn stream %0d: imm=0x%08h q_count=%0d", k, dec_immediate, q_count);
        end
        inst_mem_is_valid = 1'b0;
        step(2);

        // Illegal opcode: sticky exception, later words ignored.
        do_reset();
        drive(32'h0000_007F, 32'h0000_0010);
        step(1);
        inst_mem_is_valid = 1'b0;
        step(LAT - 1);
        check("exc.flag", 32'(exception), 32'd1);
        check("exc.pc", exc_pc, 32'h0000_0010);
        check("exc.valid", 32'(dec_valid), 32'd0);
        check("exc.ready", 32'(fetch_ready), 32'd0);
        drive(addi_k(3), 32'h0000_0014);
        step(3);
        inst_mem_is_valid = 1'b0;
        check("exc.ignored_q", 32'(q_count), 32'd0);
        check("exc.ignored_valid", 32'(dec_valid), 32'd0);
        check("exc.sticky_pc", exc_pc, 32'h0000_0010);
        $display("txn exception: exc_pc=0x%08h", exc_pc);

        // Misaligned PC fault after reset clears the previous exception.
        do_reset();
        check("mis.cleared", 32'(exception), 32'd0);
        drive(addi_k(1), 32'h0000_0022);
        step(1);
        inst_mem_is_valid = 1'b0;
        step(LAT - 1);
        check("mis.flag", 32'(exception), 32'd1);
        check("mis.pc", exc_pc, 32'h0000_0022);
        $display("txn misaligned: exc_pc=0x%08h", exc_pc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
